vxm_scheduler: RTL and testbench
================================

VXM_SCHEDULER -- requirements
Module: vxm_scheduler

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning width of the vector-count field.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning width of the SRF stream address.
REQ-003 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports req_valid[i]  input  1 and req_ready[i]  output  1, for i=0,1: per-requester handshake.
REQ-006 SHALL have ports req_op[i]  input  2, req_base[i]  input  ADDR_W, req_count[i]  input  CNT_W, req_tag[i]  input  4: instruction fields, i=0,1.
REQ-007 SHALL have ports vxm_enable  output  1 and vxm_operation  output  2: drive the vector execution unit.
REQ-008 SHALL have port srf_rd_addr  output  ADDR_W: operand stream address, valid while vxm_enable=1.
REQ-009 SHALL have ports res_valid  output  1 and res_addr  output  ADDR_W: result-capture strobe and address.
REQ-010 SHALL have ports done  output  1, done_tag  output  4, done_err  output  1, busy  output  1: completion report.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-012 SHALL assert req_ready[i] only in IDLE, and only for the requester granted that cycle; acceptance = req_valid & req_ready.
REQ-013 SHALL arbitrate round-robin: single requester wins; with both valid, the one not granted last wins; the pointer updates only on acceptance.
REQ-014 SHALL latch op, base, count and tag on acceptance in cycle T.
REQ-015 SHALL, if count>0, go IDLE->ISSUE at T+1 and assert vxm_enable in cycles T+1..T+count, with srf_rd_addr = base+k in the k-th cycle (k=0..count-1), wrapping modulo 2^ADDR_W.
REQ-016 SHALL hold vxm_operation equal to the latched op throughout ISSUE and DRAIN.
REQ-017 SHALL go ISSUE->DRAIN after the last issue cycle, and DRAIN->DONE after one cycle.
REQ-018 SHALL assert res_valid one cycle after each vxm_enable cycle, with res_addr = the srf_rd_addr of that cycle.
REQ-019 SHALL pulse done for exactly one cycle in DONE, with done_tag = latched tag, then return to IDLE.
REQ-020 SHALL, for count=0, go IDLE->DONE at T+1 with no vxm_enable and no res_valid.
REQ-021 SHALL assert busy in every non-IDLE state.
REQ-022 SHALL keep vxm_enable=0, res_valid=0 and done=0 in IDLE.
REQ-023 SHALL ignore request-field changes after acceptance; a new request is accepted no earlier than the IDLE cycle after DONE.

Reset
REQ-024 SHALL, on rst, enter IDLE and clear vxm_enable, vxm_operation, srf_rd_addr, res_valid, res_addr, done, done_tag, done_err and busy to 0, and set the RR pointer so req 0 wins ties.
REQ-025 SHALL, on rst mid-operation, abandon the instruction with no done pulse; res_valid=0 in the cycle after rst.

Configuration
REQ-026 SHALL support macro VXM_SCHED_ILLEGAL_OP_TRAP_EN.
REQ-027 With VXM_SCHED_ILLEGAL_OP_TRAP_EN defined: an accepted op!=2'b00 SHALL go IDLE->DONE at T+1 with no vxm_enable and done_err=1 on the done pulse.
REQ-028 Without it: every op SHALL be issued per REQ-015, and done_err SHALL be tied 0.

Verification
REQ-029 Single req0: op=00, base=0x10, count=3, tag=5 accepted at T -> vxm_enable T+1..T+3, addr 0x10,0x11,0x12; res_valid T+2..T+4; done with tag=5 at T+5.
REQ-030 Both valid repeatedly after reset, count=1 each -> grant order 0,1,0,1; only one req_ready high per cycle.
REQ-031 base=0xFE, count=4 -> srf_rd_addr 0xFE,0xFF,0x00,0x01.
REQ-032 count=0, tag=9 -> done with tag=9 at T+1; vxm_enable never asserted.
REQ-033 rst asserted at T+2 of a count=5 op -> all outputs 0 next cycle, no done; a new request is accepted afterwards.
REQ-034 op=01, count=2 -> with macro: done_err=1 at T+1, no issue; without macro: 2 issue cycles, done_err=0.

Source files
------------

// File: rtl/vxm_sched_if.sv
// Requester/issue/completion bundle between the instruction front end and vxm_scheduler.
interface vxm_sched_if #(
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 8
);
  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0][1:0]        req_op;
  logic [1:0][ADDR_W-1:0] req_base;
  logic [1:0][CNT_W-1:0]  req_count;
  logic [1:0][3:0]        req_tag;
  logic                   vxm_enable;
  logic [1:0]             vxm_operation;
  logic [ADDR_W-1:0]      srf_rd_addr;
  logic                   res_valid;
  logic [ADDR_W-1:0]      res_addr;
  logic                   done;
  logic [3:0]             done_tag;
  logic                   done_err;
  logic                   busy;

  modport master (
    output req_valid, req_op, req_base, req_count, req_tag,
    input  req_ready, vxm_enable, vxm_operation, srf_rd_addr, res_valid, res_addr,
    input  done, done_tag, done_err, busy
  );

  modport slave (
    input  req_valid, req_op, req_base, req_count, req_tag,
    output req_ready, vxm_enable, vxm_operation, srf_rd_addr, res_valid, res_addr,
    output done, done_tag, done_err, busy
  );
endinterface

// File: rtl/vxm_scheduler.sv
// Two-requester round-robin scheduler streaming vector operands into the VXM.
// Optional macro VXM_SCHED_ILLEGAL_OP_TRAP_EN: non-zero ops complete at once with done_err.
//
// state | meaning
// IDLE  | waiting for a request; only state that grants
// ISSUE | vxm_enable high, one operand address per cycle
// DRAIN | last result still in flight
// DONE  | one-cycle completion pulse
module vxm_scheduler #(
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  vxm_sched_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic              last_q;
  logic [1:0]        gnt;
  logic              accept;
  logic              sel;
  logic              trap;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  rem_q;
  logic [3:0]        tag_q;
  logic              res_valid_q;
  logic [ADDR_W-1:0] res_addr_q;

  // On a tie, the requester that did not win last time is granted.
  always_comb begin
    gnt = 2'b00;
    if (state_q == IDLE) begin
      if (bus.req_valid == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
      else                        gnt = bus.req_valid;
    end
  end

  assign accept = |gnt;
  assign sel    = gnt[1];

`ifdef VXM_SCHED_ILLEGAL_OP_TRAP_EN
  logic err_q;
  assign trap = (bus.req_op[sel] != 2'b00);
  always_ff @(posedge clk) begin
    if (rst)         err_q <= 1'b0;
    else if (accept) err_q <= trap;
  end
  assign bus.done_err = (state_q == DONE) & err_q;
`else
  assign trap         = 1'b0;
  assign bus.done_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept)
          state_d = ((bus.req_count[sel] == '0) || trap) ? DONE : ISSUE;
      end
      ISSUE:   if (rem_q == CNT_W'(1)) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q      <= 1'b1;
      op_q        <= '0;
      addr_q      <= '0;
      rem_q       <= '0;
      tag_q       <= '0;
      res_valid_q <= 1'b0;
      res_addr_q  <= '0;
    end else begin
      res_valid_q <= (state_q == ISSUE);
      if (state_q == ISSUE) res_addr_q <= addr_q;
      if (accept) begin
        last_q <= sel;
        op_q   <= bus.req_op[sel];
        addr_q <= bus.req_base[sel];
        rem_q  <= bus.req_count[sel];
        tag_q  <= bus.req_tag[sel];
      end else if (state_q == ISSUE) begin
        addr_q <= addr_q + ADDR_W'(1);
        rem_q  <= rem_q - CNT_W'(1);
      end
    end
  end

  assign bus.req_ready     = gnt;
  assign bus.vxm_enable    = (state_q == ISSUE);
  assign bus.vxm_operation = op_q;
  assign bus.srf_rd_addr   = addr_q;
  assign bus.res_valid     = res_valid_q;
  assign bus.res_addr      = res_addr_q;
  assign bus.done          = (state_q == DONE);
  assign bus.done_tag      = tag_q;
  assign bus.busy          = (state_q != IDLE);
endmodule

// File: tb/tb_vxm_scheduler.sv
// Directed and random stimulus for vxm_scheduler, checked against a per-instruction timeline model.
module tb_vxm_scheduler;
  localparam int CNT_W  = 8;
  localparam int ADDR_W = 8;
`ifdef VXM_SCHED_ILLEGAL_OP_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  vxm_sched_if #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) bus ();
  vxm_scheduler #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [1:0] s_op[2];
  logic [7:0] s_base[2];
  logic [7:0] s_cnt[2];
  logic [3:0] s_tag[2];

  // Model: an accepted instruction at cycle t0 defines every output by its offset j = cyc - t0.
  bit         m_act = 1'b0;
  int         t0 = 0;
  int         dj = 0;
  int         m_cnt = 0;
  logic [1:0] m_op = '0;
  logic [7:0] m_base = '0;
  logic [3:0] m_tag = '0;
  bit         m_trap = 1'b0;
  bit         last_g = 1'b1;
  bit         zero_chk = 1'b0;
  int         gq[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_check();
    int j;
    int g;
    logic [1:0] e_rdy;
    bit e_en, e_res, e_done;
    j = cyc - t0;
    if (m_act && j > dj) m_act = 1'b0;
    e_rdy = 2'b00; e_en = 1'b0; e_res = 1'b0; e_done = 1'b0;
    if (!m_act) begin
      if (bus.req_valid == 2'b11) e_rdy = last_g ? 2'b01 : 2'b10;
      else                        e_rdy = bus.req_valid;
    end else begin
      e_en   = !m_trap && j >= 1 && j <= m_cnt;
      e_res  = !m_trap && j >= 2 && j <= m_cnt + 1;
      e_done = (j == dj);
    end
    if (zero_chk) begin
      check_eq("rst_srf_rd_addr", 32'(bus.srf_rd_addr), 0);
      check_eq("rst_res_addr", 32'(bus.res_addr), 0);
      check_eq("rst_vxm_operation", 32'(bus.vxm_operation), 0);
      check_eq("rst_done_tag", 32'(bus.done_tag), 0);
      zero_chk = 1'b0;
    end
    check_eq("req_ready", 32'(bus.req_ready), 32'(e_rdy));
    check_eq("vxm_enable", 32'(bus.vxm_enable), 32'(e_en));
    check_eq("res_valid", 32'(bus.res_valid), 32'(e_res));
    check_eq("done", 32'(bus.done), 32'(e_done));
    check_eq("busy", 32'(bus.busy), 32'(m_act));
    check_eq("done_err", 32'(bus.done_err), 32'(e_done && m_trap));
    if (e_en)  check_eq("srf_rd_addr", 32'(bus.srf_rd_addr), 32'(8'(m_base + j - 1)));
    if (m_act && j < dj) check_eq("vxm_operation", 32'(bus.vxm_operation), 32'(m_op));
    if (e_res) check_eq("res_addr", 32'(bus.res_addr), 32'(8'(m_base + j - 2)));
    if (e_done) check_eq("done_tag", 32'(bus.done_tag), 32'(m_tag));
    if (bus.req_ready != 2'b00) gq.push_back(int'(bus.req_ready[1]));
    if (e_rdy != 2'b00 && !rst) begin
      g      = int'(e_rdy[1]);
      m_act  = 1'b1;
      t0     = cyc;
      m_op   = bus.req_op[g];
      m_base = bus.req_base[g];
      m_cnt  = int'(bus.req_count[g]);
      m_tag  = bus.req_tag[g];
      last_g = e_rdy[1];
      m_trap = TRAP && (m_op != 2'b00);
      dj     = (m_cnt == 0 || m_trap) ? 1 : m_cnt + 2;
    end
    if (rst) begin
      m_act    = 1'b0;
      last_g   = 1'b1;
      zero_chk = 1'b1;
    end
  endtask

  task automatic cyc_go(input logic r, input logic [1:0] v);
    @(posedge clk);
    cyc++;
    #1;
    rst           = r;
    bus.req_valid = v;
    for (int i = 0; i < 2; i++) begin
      bus.req_op[i]    = s_op[i];
      bus.req_base[i]  = s_base[i];
      bus.req_count[i] = s_cnt[i];
      bus.req_tag[i]   = s_tag[i];
    end
    @(negedge clk);
    model_check();
  endtask

  task automatic stage(input int i, input logic [1:0] op, input logic [7:0] base,
                       input logic [7:0] cnt, input logic [3:0] tag);
    s_op[i] = op; s_base[i] = base; s_cnt[i] = cnt; s_tag[i] = tag;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc_go(1'b0, 2'b00);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) stage(i, 2'b00, 8'h00, 8'h00, 4'h0);
    bus.req_valid = 2'b00;
    bus.req_op    = '0;
    bus.req_base  = '0;
    bus.req_count = '0;
    bus.req_tag   = '0;

    cyc_go(1'b1, 2'b00);
    cyc_go(1'b1, 2'b00);
    idle(2);

    // single op on requester 0
    stage(0, 2'b00, 8'h10, 8'd3, 4'd5);
    cyc_go(1'b0, 2'b01);
    idle(7);

    // both requesters hammering after reset
    cyc_go(1'b1, 2'b00);
    gq.delete();
    stage(0, 2'b00, 8'h20, 8'd1, 4'd1);
    stage(1, 2'b00, 8'h30, 8'd1, 4'd2);
    repeat (14) cyc_go(1'b0, 2'b11);
    check_eq("rr_grant_count", 32'(gq.size() >= 4), 1);
    for (int i = 0; i < 4; i++)
      if (i < gq.size()) check_eq("rr_order", 32'(gq[i]), 32'(i % 2));
    idle(5);

    // address wrap
    stage(1, 2'b00, 8'hFE, 8'd4, 4'd3);
    cyc_go(1'b0, 2'b10);
    idle(7);

    // zero count
    stage(0, 2'b00, 8'h40, 8'd0, 4'd9);
    cyc_go(1'b0, 2'b01);
    idle(3);

    // reset mid-operation, then a fresh request
    stage(0, 2'b00, 8'h50, 8'd5, 4'd7);
    cyc_go(1'b0, 2'b01);
    cyc_go(1'b0, 2'b00);
    cyc_go(1'b1, 2'b00);
    idle(4);
    stage(1, 2'b00, 8'h60, 8'd2, 4'd4);
    cyc_go(1'b0, 2'b10);
    idle(5);

    // non-zero op
    stage(0, 2'b01, 8'h70, 8'd2, 4'd6);
    cyc_go(1'b0, 2'b01);
    idle(5);

    // random traffic with field churn and occasional reset
    repeat (800) begin
      for (int i = 0; i < 2; i++)
        stage(i, 2'($urandom), 8'($urandom), 8'($urandom_range(0, 6)), 4'($urandom));
      cyc_go(1'($urandom_range(0, 79) == 0), 2'($urandom));
    end
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
